// File: rtl/uart_tx_pkg.sv
// Shared types and constants for the UART transmit serializer.
// Even parity is enabled by defining UART_TX_PARITY_EN.
package uart_tx_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StReq,
        StWait,
        StStart,
        StData,
        StPar,
        StStop
    } tx_state_e;

    localparam logic [7:0] TX_IDLE_BYTE = 8'hFF;
    localparam logic [7:0] TX_LF_BYTE   = 8'h0A;

    function automatic logic even_parity(input logic [7:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period tick generator: pulses once every ClksPerBit enabled cycles.
// The count is cleared by restart_i so each frame starts on a full bit period.
module uart_baud_tick #(
    parameter int unsigned ClksPerBit = 434
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic en_i,
    input  logic restart_i,
    output logic tick_o
);

    localparam int unsigned CntW = (ClksPerBit > 1) ? $clog2(ClksPerBit) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(ClksPerBit - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    assign tick_o = en_i && (cnt_q == CntMax);

    always_comb begin
        cnt_d = cnt_q;
        if (restart_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = tick_o ? '0 : cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx_serializer.sv
// Fetches bytes from an upstream memory and sends them as UART frames (8N1, or 8E1
// when UART_TX_PARITY_EN is defined). A fetched 8'hFF means "no data" and sends nothing.
module uart_tx_serializer
    import uart_tx_pkg::*;
#(
    parameter int unsigned CLK_FREQ = 50000000,
    parameter int unsigned BAUD     = 115200
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] iTX_DATA,
    input  logic       iTX_EN,
    output logic       oTX_REQ,
    output logic       oTX,
    output logic       oBUSY,
    output logic       oLINE_DONE
);

    localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD;

    tx_state_e  state_q, state_d;
    logic [7:0] shift_q, shift_d;
    logic [2:0] bit_idx_q, bit_idx_d;
    logic       lf_q, lf_d;
    logic       tx_q, tx_d;
    logic       line_done_q, line_done_d;
`ifdef UART_TX_PARITY_EN
    logic       par_q, par_d;
`endif

    logic tick;
    logic in_frame;
    logic restart;

    assign in_frame = (state_q == StStart) || (state_q == StData) ||
                      (state_q == StPar)   || (state_q == StStop);
    assign restart  = (state_q == StWait);

    uart_baud_tick #(
        .ClksPerBit(CLKS_PER_BIT)
    ) u_baud_tick (
        .clk_i    (clk),
        .rst_ni   (reset),
        .en_i     (in_frame),
        .restart_i(restart),
        .tick_o   (tick)
    );

    // tx_d always carries the level of the bit about to start, so oTX is a pure register.
    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        bit_idx_d   = bit_idx_q;
        lf_d        = lf_q;
        tx_d        = tx_q;
        line_done_d = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_d       = par_q;
`endif
        unique case (state_q)
            StIdle: begin
                tx_d = 1'b1;
                if (iTX_EN) begin
                    state_d = StReq;
                end
            end
            StReq: begin
                state_d = StWait;
            end
            StWait: begin
                if (iTX_DATA == TX_IDLE_BYTE) begin
                    state_d = StIdle;
                end else begin
                    shift_d   = iTX_DATA;
                    lf_d      = (iTX_DATA == TX_LF_BYTE);
                    bit_idx_d = '0;
                    tx_d      = 1'b0;
                    state_d   = StStart;
`ifdef UART_TX_PARITY_EN
                    par_d     = even_parity(iTX_DATA);
`endif
                end
            end
            StStart: begin
                if (tick) begin
                    tx_d    = shift_q[0];
                    state_d = StData;
                end
            end
            StData: begin
                if (tick) begin
                    if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        tx_d    = par_q;
                        state_d = StPar;
`else
                        tx_d    = 1'b1;
                        state_d = StStop;
`endif
                    end else begin
                        shift_d   = {1'b0, shift_q[7:1]};
                        tx_d      = shift_q[1];
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            StPar: begin
                if (tick) begin
                    tx_d    = 1'b1;
                    state_d = StStop;
                end
            end
`endif
            StStop: begin
                if (tick) begin
                    line_done_d = lf_q;
                    state_d     = iTX_EN ? StReq : StIdle;
                end
            end
            default: begin
                tx_d    = 1'b1;
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            shift_q     <= '0;
            bit_idx_q   <= '0;
            lf_q        <= 1'b0;
            tx_q        <= 1'b1;
            line_done_q <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            bit_idx_q   <= bit_idx_d;
            lf_q        <= lf_d;
            tx_q        <= tx_d;
            line_done_q <= line_done_d;
`ifdef UART_TX_PARITY_EN
            par_q       <= par_d;
`endif
        end
    end

    assign oTX        = tx_q;
    assign oTX_REQ    = (state_q == StReq);
    assign oBUSY      = (state_q != StIdle);
    assign oLINE_DONE = line_done_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed bench for uart_tx_serializer at CLK_FREQ=1000, BAUD=100 (10 clocks per bit).
// Define UART_TX_PARITY_EN for both RTL and bench to check the 11-bit parity frames.
module tb_uart_tx_serializer;

    localparam int unsigned CPB = 10;
`ifdef UART_TX_PARITY_EN
    localparam int unsigned FB = 11;
    // {stop, parity, d7..d0, start}
    localparam logic [10:0] FR_63 = 11'b1_0_01100011_0;
    localparam logic [10:0] FR_0A = 11'b1_0_00001010_0;
    localparam logic [10:0] FR_55 = 11'b1_0_01010101_0;
    localparam logic [10:0] FR_61 = 11'b1_1_01100001_0;
`else
    localparam int unsigned FB = 10;
    // {stop, d7..d0, start}
    localparam logic [10:0] FR_63 = 11'b0_1_01100011_0;
    localparam logic [10:0] FR_0A = 11'b0_1_00001010_0;
    localparam logic [10:0] FR_55 = 11'b0_1_01010101_0;
    localparam logic [10:0] FR_61 = 11'b0_1_01100001_0;
`endif

    logic       clk;
    logic       reset;
    logic [7:0] iTX_DATA;
    logic       iTX_EN;
    logic       oTX_REQ;
    logic       oTX;
    logic       oBUSY;
    logic       oLINE_DONE;

    int total = 0;
    int bad   = 0;

    uart_tx_serializer #(
        .CLK_FREQ(1000),
        .BAUD    (100)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .iTX_DATA  (iTX_DATA),
        .iTX_EN    (iTX_EN),
        .oTX_REQ   (oTX_REQ),
        .oTX       (oTX),
        .oBUSY     (oBUSY),
        .oLINE_DONE(oLINE_DONE)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Returns at the negedge where oTX_REQ is high, or after a bounded wait.
    task automatic wait_req(input string tag);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (oTX_REQ !== 1'b1 && n < 20);
        check({tag, "_req_seen"}, oTX_REQ, 1'b1);
    endtask

    // Sends one byte; drop_idx < 0 drops iTX_EN right after the request,
    // otherwise it is dropped in the first cycle of that frame bit.
    task automatic send_frame(input string tag, input logic [7:0] b, input logic [10:0] fr,
                              input logic lf, input int drop_idx);
        iTX_DATA = b;
        iTX_EN   = 1'b1;
        wait_req(tag);
        if (drop_idx < 0) iTX_EN = 1'b0;
        @(negedge clk);
        check({tag, "_wait_busy"}, oBUSY, 1'b1);
        check({tag, "_wait_tx"}, oTX, 1'b1);
        @(negedge clk);
        for (int i = 0; i < FB; i++) begin
            for (int c = 0; c < CPB; c++) begin
                if (i == drop_idx && c == 0) iTX_EN = 1'b0;
                // byte must already be latched
                if (i == 2 && c == 0) iTX_DATA = 8'h00;
                check($sformatf("%s_tx_bit%0d_c%0d", tag, i, c), oTX, fr[i]);
                check($sformatf("%s_busy_bit%0d", tag, i), oBUSY, 1'b1);
                check($sformatf("%s_noreq_bit%0d", tag, i), oTX_REQ, 1'b0);
                check($sformatf("%s_nold_bit%0d", tag, i), oLINE_DONE, 1'b0);
                @(negedge clk);
            end
        end
        check({tag, "_line_done"}, oLINE_DONE, lf);
        check({tag, "_idle_busy"}, oBUSY, 1'b0);
        check({tag, "_idle_tx"}, oTX, 1'b1);
        @(negedge clk);
        check({tag, "_line_done_gone"}, oLINE_DONE, 1'b0);
        for (int k = 0; k < 10; k++) begin
            check({tag, "_no_extra_req"}, oTX_REQ, 1'b0);
            @(negedge clk);
        end
    endtask

    initial begin
        int n;
        reset    = 1'b0;
        iTX_EN   = 1'b0;
        iTX_DATA = 8'hFF;
        repeat (3) @(negedge clk);
        check("rst_tx", oTX, 1'b1);
        check("rst_req", oTX_REQ, 1'b0);
        check("rst_busy", oBUSY, 1'b0);
        check("rst_line_done", oLINE_DONE, 1'b0);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_tx", oTX, 1'b1);
        check("idle_busy", oBUSY, 1'b0);
        check("idle_req", oTX_REQ, 1'b0);

        // Plain 8'h63 frame, no line-done
        send_frame("b63", 8'h63, FR_63, 1'b0, -1);

        // Empty fetch: no frame bit, back to idle
        iTX_DATA = 8'hFF;
        iTX_EN   = 1'b1;
        wait_req("ff");
        iTX_EN = 1'b0;
        @(negedge clk);
        check("ff_wait_busy", oBUSY, 1'b1);
        @(negedge clk);
        check("ff_idle_busy", oBUSY, 1'b0);
        for (int k = 0; k < 20; k++) begin
            check("ff_tx_high", oTX, 1'b1);
            check("ff_no_req", oTX_REQ, 1'b0);
            @(negedge clk);
        end

        // Newline: oLINE_DONE pulses once after the stop bit
        send_frame("b0a", 8'h0A, FR_0A, 1'b1, -1);

        // Enable dropped in the 3rd data bit: frame completes, then idle
        send_frame("drop", 8'h55, FR_55, 1'b0, 3);

        // 8'h61: three ones (parity bit 1 in the parity build)
        send_frame("b61", 8'h61, FR_61, 1'b0, -1);

        // Reset during data bit 5 (frame bit 6, a low bit of 8'h55)
        iTX_DATA = 8'h55;
        iTX_EN   = 1'b1;
        wait_req("rst_mid");
        @(negedge clk);
        @(negedge clk);
        repeat (6 * CPB + 4) @(negedge clk);
        check("rst_mid_pre_tx", oTX, 1'b0);
        check("rst_mid_pre_busy", oBUSY, 1'b1);
        reset = 1'b0;
        #1;
        check("rst_mid_tx", oTX, 1'b1);
        check("rst_mid_busy", oBUSY, 1'b0);
        check("rst_mid_req", oTX_REQ, 1'b0);
        @(negedge clk);
        check("rst_mid_hold_tx", oTX, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        check("rst_rel_first_req", oTX_REQ, 1'b1);
        check("rst_rel_tx", oTX, 1'b1);
        iTX_EN = 1'b0;
        n = 0;
        while (oBUSY !== 1'b0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("rst_rel_frame_end", oBUSY, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
